// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I fetch queue: the canonical NOP and the
// layout of one decode-queue entry {pc, instr, fault}.
package rv32i_pkg;

    // addi x0, x0, 0 -- substituted for the instruction word of faulted fetches
    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    // Instruction word plus fault flag; the PC field (XLEN bits) sits above them
    localparam int ENTRY_PAYLOAD_W = 33;

    // Width of one queue entry for a given address width
    function automatic int entry_width(input int xlen);
        return xlen + ENTRY_PAYLOAD_W;
    endfunction

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head, used both as the
// PC-tag FIFO for in-flight requests and as the decode instruction queue.
// Pointers wrap naturally, so DEPTH must be a power of two (>=2).
module rv32i_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A clear discards everything; a push into a full FIFO is only allowed alongside a pop
    assign do_pop  = pop_i & ~empty_o & ~clear_i;
    assign do_push = push_i & ~clear_i & (~full_o | do_pop);

    // Next-state pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
            else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy guards every read
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Flag underflow and overflow attempts from the surrounding logic
    always @(posedge clk_in) begin
        if (!reset_in && !clear_i) begin
            assert (!(pop_i && empty_o)) else $error("rv32i_sync_fifo: pop from empty fifo");
            assert (!(push_i && full_o && !pop_i)) else $error("rv32i_sync_fifo: push into full fifo");
        end
    end

endmodule

// File: rtl/rv32i_fetch_queue.sv
// Fetch queue between the PC generator and decode: issues imem requests under
// a credit limit, tags responses with their PC, buffers {pc, instr, fault} in
// order, and drops responses that belong to requests made before a flush.
module rv32i_fetch_queue
    import rv32i_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic [XLEN-1:0] fetch_address_i,
    input  logic            fetch_valid_i,
    output logic            fetch_stall_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_err_i,
    output logic            dec_valid_o,
    output logic [31:0]     dec_instr_o,
    output logic [XLEN-1:0] dec_pc_o,
    output logic            dec_fault_o,
    input  logic            dec_ready_i
);
    localparam int EW = entry_width(XLEN);
    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam int QW = $clog2(DEPTH) + 1;

    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   discard_q, discard_d;
    logic [OW:0]     inflight;
    logic [QW-1:0]   q_count;
    logic            q_full, q_empty;
    logic [EW-1:0]   q_head, q_push_data;
    logic            q_push, q_pop;
    logic [XLEN-1:0] tag_pc;
    logic [OW-1:0]   tag_count;
    logic            tag_full, tag_empty;
    logic            aligned, can_issue, handshake, resp_live, mis_accept;
    logic            unused_tag_count;

    // Responses still owed by memory, live or to be discarded, all consume credit
    assign inflight  = {1'b0, outst_q} + {1'b0, discard_q};
    assign can_issue = (int'(inflight) < MAX_OUTST) && (int'(q_count) + int'(inflight) < DEPTH);
    assign aligned   = (fetch_address_i[1:0] == 2'b00);

    assign imem_req_o  = ~reset_in & fetch_valid_i & can_issue & ~flush_i & aligned;
    assign imem_addr_o = fetch_address_i;
    assign handshake   = imem_req_o & imem_gnt_i;

    // A misaligned PC never goes to memory; it becomes a fault entry once older fetches are home
    assign mis_accept    = ~reset_in & fetch_valid_i & ~aligned & ~flush_i & (outst_q == '0) & ~q_full;
    assign fetch_stall_o = fetch_valid_i & ~handshake & ~mis_accept;

    // Responses to pre-flush requests (discard_q != 0) and responses in the flush cycle are dropped
    assign resp_live = imem_rvalid_i & (discard_q == '0) & ~flush_i;

    assign q_push      = resp_live | mis_accept;
    assign q_push_data = resp_live
                       ? {tag_pc, (imem_err_i ? RV32I_NOP : imem_rdata_i), imem_err_i}
                       : {fetch_address_i, RV32I_NOP, 1'b1};
    assign q_pop       = dec_valid_o & dec_ready_i & ~flush_i;

    assign dec_valid_o = ~q_empty;
    assign dec_pc_o    = dec_valid_o ? q_head[EW-1 -: XLEN] : '0;
    assign dec_instr_o = dec_valid_o ? q_head[32:1] : 32'h0;
    assign dec_fault_o = dec_valid_o & q_head[0];

    assign unused_tag_count = ^tag_count;

    // In-flight and discard counter next state
    always_comb begin
        outst_d   = outst_q;
        discard_d = discard_q;
        if (flush_i) begin
            outst_d   = '0;
            discard_d = discard_q + outst_q - OW'(imem_rvalid_i);
        end else begin
            if (handshake && !resp_live)      outst_d = outst_q + OW'(1);
            else if (!handshake && resp_live) outst_d = outst_q - OW'(1);
            if (imem_rvalid_i && discard_q != '0) discard_d = discard_q - OW'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    // Memory must never answer a request it was not given
    always @(posedge clk_in) begin
        if (!reset_in) begin
            assert (!(imem_rvalid_i && outst_q == '0 && discard_q == '0))
                else $error("rv32i_fetch_queue: rvalid with nothing in flight");
            assert (!(resp_live && tag_empty))
                else $error("rv32i_fetch_queue: response with empty tag fifo");
            assert (!(handshake && tag_full))
                else $error("rv32i_fetch_queue: request with full tag fifo");
        end
    end

    rv32i_sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_tag_fifo (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .clear_i     (flush_i),
        .push_i      (handshake),
        .push_data_i (fetch_address_i),
        .pop_i       (resp_live),
        .head_o      (tag_pc),
        .count_o     (tag_count),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    rv32i_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_queue (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .clear_i     (flush_i),
        .push_i      (q_push),
        .push_data_i (q_push_data),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .count_o     (q_count),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

endmodule
